// File: rtl/kernel_pkg.sv
// Shared definitions for the Gaussian kernel generator: array size default,
// FSM state encoding and the offline-generated weight table.
package kernel_pkg;

  localparam int MAX_KERNAL_DEF = 7;
  localparam int D2_MAX         = 18;
  localparam int D2W            = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // round(255 * exp(-d2 / (2*s^2))), half up; row 0 is the delta kernel.
  localparam logic [7:0] WEIGHT_TAB [8][D2_MAX+1] = '{
    '{8'd255, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,
      8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0},
    '{8'd255, 8'd155, 8'd94,  8'd57,  8'd35,  8'd21,  8'd13,  8'd8,   8'd5,   8'd3,
      8'd2,   8'd1,   8'd1,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0},
    '{8'd255, 8'd225, 8'd199, 8'd175, 8'd155, 8'd136, 8'd120, 8'd106, 8'd94,  8'd83,
      8'd73,  8'd64,  8'd57,  8'd50,  8'd44,  8'd39,  8'd35,  8'd30,  8'd27},
    '{8'd255, 8'd241, 8'd228, 8'd216, 8'd204, 8'd193, 8'd183, 8'd173, 8'd164, 8'd155,
      8'd146, 8'd138, 8'd131, 8'd124, 8'd117, 8'd111, 8'd105, 8'd99,  8'd94},
    '{8'd255, 8'd247, 8'd240, 8'd232, 8'd225, 8'd218, 8'd211, 8'd205, 8'd199, 8'd192,
      8'd187, 8'd181, 8'd175, 8'd170, 8'd165, 8'd160, 8'd155, 8'd150, 8'd145},
    '{8'd255, 8'd250, 8'd245, 8'd240, 8'd235, 8'd231, 8'd226, 8'd222, 8'd217, 8'd213,
      8'd209, 8'd205, 8'd201, 8'd197, 8'd193, 8'd189, 8'd185, 8'd182, 8'd178},
    '{8'd255, 8'd251, 8'd248, 8'd245, 8'd241, 8'd238, 8'd235, 8'd231, 8'd228, 8'd225,
      8'd222, 8'd219, 8'd216, 8'd213, 8'd210, 8'd207, 8'd204, 8'd201, 8'd199},
    '{8'd255, 8'd252, 8'd250, 8'd247, 8'd245, 8'd242, 8'd240, 8'd237, 8'd235, 8'd233,
      8'd230, 8'd228, 8'd226, 8'd223, 8'd221, 8'd219, 8'd217, 8'd214, 8'd212}
  };

  // Squared distances beyond the table cannot occur for a 7x7 array; return 0.
  function automatic logic [7:0] gauss_weight(input logic [2:0] sigma,
                                              input logic [D2W-1:0] d2);
    logic [7:0] w;
    w = 8'd0;
    if (d2 <= D2W'(D2_MAX)) w = WEIGHT_TAB[sigma][d2];
    return w;
  endfunction

endpackage

// File: rtl/init_kernel_rom.sv
// Combinational (sigma, squared distance) -> 8-bit Gaussian weight lookup.
module gauss_weight_rom
  import kernel_pkg::*;
(
  input  logic [2:0]     i_sigma,
  input  logic [D2W-1:0] i_d2,
  output logic [7:0]     o_weight
);

  assign o_weight = gauss_weight(i_sigma, i_d2);

endmodule

// File: rtl/init_kernel.sv
// Sequential 2-D Gaussian kernel builder: one weight per cycle, row-major,
// centred in a MAX_KERNAL x MAX_KERNAL array, with a running weight sum.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE    | after reset, waiting for start
//   FILL    | writing one element per cycle, row-major
//   DONE    | kernel and sum complete and held, done=1
module init_kernel
  import kernel_pkg::*;
#(
  parameter int MAX_KERNAL = MAX_KERNAL_DEF
) (
  input  logic                                          clk,
  input  logic                                          n_rst,
  input  logic                                          start,
  input  logic [2:0]                                    sigma,
  input  logic [$clog2(MAX_KERNAL)-1:0]                 kernel_size,
  output logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0]    kernel,
  output logic [63:0]                                   sum,
  output logic                                          done
);

  localparam int KW  = $clog2(MAX_KERNAL);
  localparam int SQW = 2 * KW + 1;
  localparam logic [KW-1:0] C_IDX    = KW'((MAX_KERNAL - 1) / 2);
  localparam logic [KW-1:0] LAST_IDX = KW'(MAX_KERNAL - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_load;
  logic           w_write;

  logic [KW-1:0]  r_row;
  logic [KW-1:0]  r_col;
  logic [2:0]     r_sigma;
  logic [KW-1:0]  r_half;

  int             w_keff;
  logic [KW-1:0]  w_half;
  logic [KW-1:0]  w_adx;
  logic [KW-1:0]  w_ady;
  logic [SQW-1:0] w_d2_full;
  logic [D2W-1:0] w_d2;
  logic [7:0]     w_rom;
  logic [7:0]     w_weight;
  logic           w_in_win;

  // Half-width of the requested window: even sizes round down, 0 means 1.
  always_comb begin
    w_keff = int'(kernel_size);
    if (w_keff == 0) w_keff = 1;
    else if ((w_keff % 2) == 0) w_keff = w_keff - 1;
    if (w_keff > MAX_KERNAL) w_keff = MAX_KERNAL;
    w_half = KW'((w_keff - 1) / 2);
  end

  assign w_adx     = (r_row >= C_IDX) ? (r_row - C_IDX) : (C_IDX - r_row);
  assign w_ady     = (r_col >= C_IDX) ? (r_col - C_IDX) : (C_IDX - r_col);
  assign w_d2_full = SQW'(w_adx) * SQW'(w_adx) + SQW'(w_ady) * SQW'(w_ady);
  assign w_d2      = D2W'(w_d2_full);
  assign w_in_win  = (w_adx <= r_half) && (w_ady <= r_half);

  gauss_weight_rom u_rom (
    .i_sigma  (r_sigma),
    .i_d2     (w_d2),
    .o_weight (w_rom)
  );

  assign w_weight = w_in_win ? w_rom : 8'd0;
  assign done     = (r_state == ST_DONE);

  // State register.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and datapath strobes; start is only honoured outside FILL.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        w_write = 1'b1;
        if ((r_row == LAST_IDX) && (r_col == LAST_IDX)) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch parameters on start, then write one weight and accumulate per cycle.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      kernel  <= '0;
      sum     <= 64'd0;
      r_row   <= '0;
      r_col   <= '0;
      r_sigma <= 3'd0;
      r_half  <= '0;
    end else if (w_load) begin
      kernel  <= '0;
      sum     <= 64'd0;
      r_row   <= '0;
      r_col   <= '0;
      r_sigma <= sigma;
      r_half  <= w_half;
    end else if (w_write) begin
      kernel[r_row][r_col] <= w_weight;
      sum                  <= sum + 64'(w_weight);
      if (r_col == LAST_IDX) begin
        r_col <= '0;
        r_row <= (r_row == LAST_IDX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_init_kernel.sv
// Bench for init_kernel: directed scenarios plus random builds, each checked
// against a floating-point Gaussian model of the expected kernel and sum.
module tb_init_kernel;

  localparam int MAXK = 7;
  localparam int CTR  = (MAXK - 1) / 2;

  logic                             clk;
  logic                             n_rst;
  logic                             start;
  logic [2:0]                       sigma;
  logic [2:0]                       kernel_size;
  logic [MAXK-1:0][MAXK-1:0][7:0]   kernel;
  logic [63:0]                      sum;
  logic                             done;

  int     checks;
  int     errors;
  int     exp_k [MAXK][MAXK];
  longint exp_sum;

  init_kernel #(.MAX_KERNAL(MAXK)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .sigma       (sigma),
    .kernel_size (kernel_size),
    .kernel      (kernel),
    .sum         (sum),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected kernel straight from the Gaussian formula.
  task automatic build_model(input int s, input int k);
    int keff, h, dx, dy, d2, w;
    keff = (k == 0) ? 1 : (((k % 2) == 0) ? k - 1 : k);
    if (keff > MAXK) keff = MAXK;
    h = (keff - 1) / 2;
    exp_sum = 0;
    for (int r = 0; r < MAXK; r++) begin
      for (int c = 0; c < MAXK; c++) begin
        dx = (r > CTR) ? r - CTR : CTR - r;
        dy = (c > CTR) ? c - CTR : CTR - c;
        d2 = dx * dx + dy * dy;
        if (dx > h || dy > h) w = 0;
        else if (s == 0) w = (d2 == 0) ? 255 : 0;
        else w = int'($floor(255.0 * $exp(-real'(d2) / (2.0 * real'(s * s))) + 0.5));
        if (w > 255) w = 255;
        exp_k[r][c] = w;
        exp_sum += w;
      end
    end
  endtask

  task automatic check_kernel(input string tag);
    int nbad, br, bc;
    nbad = 0; br = 0; bc = 0;
    for (int r = 0; r < MAXK; r++)
      for (int c = 0; c < MAXK; c++)
        if (int'(kernel[r][c]) != exp_k[r][c]) begin
          if (nbad == 0) begin br = r; bc = c; end
          nbad++;
        end
    checks++;
    assert (nbad === 0) else begin
      errors++;
      $error("FAIL %s: %0d wrong weights, first [%0d][%0d] observed %0d expected %0d",
             tag, nbad, br, bc, kernel[br][bc], exp_k[br][bc]);
    end
  endtask

  task automatic check_zero(input string tag);
    int nz;
    nz = 0;
    for (int r = 0; r < MAXK; r++)
      for (int c = 0; c < MAXK; c++)
        if (kernel[r][c] !== 8'd0) nz++;
    chk(tag, nz, 0);
  endtask

  // Present a start pulse sampled at the next rising edge, then scramble inputs.
  task automatic do_start(input int s, input int k);
    @(negedge clk);
    sigma       = 3'(s);
    kernel_size = 3'(k);
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    sigma       = 3'($urandom);
    kernel_size = 3'($urandom);
  endtask

  // Count edges after the start edge until done is seen; -1 if it never rises.
  task automatic wait_done(input int n0, output int lat);
    lat = -1;
    for (int n = n0 + 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_build(input string tag, input int s, input int k);
    int lat;
    build_model(s, k);
    do_start(s, k);
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_sum_clr"}, sum, 0);
    check_zero({tag, "_kern_clr"});
    wait_done(0, lat);
    chk({tag, "_latency"}, lat, 49);
    check_kernel({tag, "_kernel"});
    chk({tag, "_sum"}, sum, exp_sum);
  endtask

  initial begin
    int lat, s, k;
    checks      = 0;
    errors      = 0;
    n_rst       = 1'b1;
    start       = 1'b0;
    sigma       = 3'd0;
    kernel_size = 3'd0;

    #12;
    check_zero("rst_kernel");
    chk("rst_sum", sum, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("idle_kernel");
    chk("idle_sum", sum, 0);
    chk("idle_done", done, 0);

    run_build("s2k3", 2, 3);
    chk("s2k3_center", kernel[3][3], 255);
    chk("s2k3_edge_n", kernel[2][3], 225);
    chk("s2k3_edge_w", kernel[3][2], 225);
    chk("s2k3_diag", kernel[4][4], 199);
    chk("s2k3_outside", kernel[1][3], 0);
    chk("s2k3_sum_lit", sum, 1951);
    repeat (5) @(posedge clk);
    #1;
    chk("s2k3_hold_done", done, 1);
    chk("s2k3_hold_sum", sum, 1951);

    run_build("s1k3", 1, 3);
    chk("s1k3_edge", kernel[4][3], 155);
    chk("s1k3_diag", kernel[2][4], 94);
    chk("s1k3_sum_lit", sum, 1251);

    run_build("s1k1", 1, 1);
    chk("s1k1_sum_lit", sum, 255);

    run_build("s0k7", 0, 7);
    chk("s0k7_sum_lit", sum, 255);

    run_build("s2k4", 2, 4);
    chk("s2k4_sum_lit", sum, 1951);

    run_build("s3k0", 3, 0);
    run_build("s4k7", 4, 7);

    // Second start partway through FILL must not disturb the build.
    build_model(5, 5);
    do_start(5, 5);
    repeat (9) @(posedge clk);
    do_start(1, 1);
    wait_done(10, lat);
    chk("refill_latency", lat, 49);
    check_kernel("refill_kernel");
    chk("refill_sum", sum, exp_sum);

    // Asynchronous reset in the middle of a build.
    do_start(3, 5);
    repeat (20) @(posedge clk);
    #2;
    n_rst = 1'b1;
    #1;
    check_zero("midrst_kernel");
    chk("midrst_sum", sum, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_idle_done", done, 0);
    run_build("after_rst", 3, 5);

    for (int it = 0; it < 12; it++) begin
      s = int'($urandom_range(0, 7));
      k = int'($urandom_range(0, 7));
      run_build($sformatf("rand%0d_s%0dk%0d", it, s, k), s, k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/init_kernel.md
Name: init_kernel

Overview:
- Sequential generator of a 2-D Gaussian convolution kernel for the ISP front-end smoothing stage (ahead of FAST corner detection).
- On a `start` pulse it latches `sigma` and `kernel_size`. It then fills a MAX_KERNAL×MAX_KERNAL array of 8-bit weights, one element per cycle, centred in the array.
- It accumulates the weight sum for later normalisation and raises `done` when the kernel is complete.

Parameters:
- MAX_KERNAL, default 7, kernel array edge length; odd, 3..7.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  reset; asynchronous and active-high (n_rst=1 clears all state immediately).
- start  input  1  single-cycle request to build a kernel.
- sigma  input  3  Gaussian standard deviation, integer 0..7.
- kernel_size  input  $clog2(MAX_KERNAL)  requested kernel edge length (odd).
- kernel  output  MAX_KERNAL×MAX_KERNAL×8  weight array, indexed [row][col].
- sum  output  64  sum of all written weights.
- done  output  1  high while a completed kernel is held.

Behaviour:
- Reset clears kernel to all 0, sum to 0 and done to 0, and puts the FSM in IDLE. Reset mid-build aborts the build with no partial result retained.
- FSM states: IDLE, FILL, DONE.
- IDLE/DONE with start=1 at edge T0:
  - latch sigma as s and size as k;
  - clear kernel and sum;
  - done←0;
  - row=col=0;
  - go to FILL.
- FILL, edges T1..T(MAX²), row-major:
  - write kernel[row][col] = w(row,col);
  - sum += w;
  - advance col, wrapping to 0 and incrementing row.
- After writing element (MAX-1,MAX-1), go to DONE with done=1 at the same edge. Latency: done rises MAX² = 49 cycles after the start-sampling edge.
- start while in FILL is ignored. Input changes after T0 have no effect on the build in progress.
- DONE holds kernel, sum and done=1 until the next start or reset.
- Kernel size rules:
  - centre index c=(MAX-1)/2 (3 for default);
  - effective size k'=k if odd, k-1 if even, 1 if k=0, clamped to MAX;
  - half-width h=(k'-1)/2.
- Weights:
  - dx=row-c, dy=col-c, d2=dx²+dy²;
  - if |dx|>h or |dy|>h, w=0;
  - else w = round(255·exp(-d2 / (2·s²))), round half up, saturate to 8 bits;
  - s=0 is a delta: w=255 at the centre, 0 elsewhere.
- Centre weight is always 255.
- Reference weight values:
  - s=1: d2=1→155, d2=2→94;
  - s=2: d2=1→225, d2=2→199.
- Weights come from a constant ROM indexed by (s, d2), d2 0..2·c² (0..18). No runtime exp.
- sum is zero-extended unsigned accumulation; no overflow is possible at this size.

Decomposition:
- Shared package `kernel_pkg`:
  - MAX_KERNAL default constant;
  - FSM state enum;
  - constant weight table and function gauss_weight(sigma, d2) returning 8 bits, generated offline from the formula above.
- One sub-module is natural: `gauss_weight_rom`, a combinational lookup of (sigma, d2) → weight.
- Counters, FSM and accumulator stay in init_kernel.

Test Plan:
- Reset: assert n_rst with start=0 → kernel all 0, sum=0, done=0. Release → values unchanged, FSM idle, done stays 0.
- sigma=2, kernel_size=3, start pulse → done rises exactly 49 cycles after the start edge. Then:
  - kernel[3][3]=255;
  - kernel[2][3]=kernel[3][2]=kernel[4][3]=kernel[3][4]=225;
  - four diagonals=199;
  - all other entries 0;
  - sum=1951.
- sigma=1, kernel_size=3 → edge neighbours 155, diagonals 94, sum=1251. sigma=1, kernel_size=1 → only kernel[3][3]=255, sum=255.
- sigma=0, kernel_size=7 → delta kernel, sum=255. kernel_size=4 → built as size 3 (same result as the size-3 case for equal sigma).
- start re-pulsed during FILL → ignored, build completes at the original cycle. start in DONE → done drops next cycle, kernel cleared, rebuild completes 49 cycles later.
- Reset asserted at cycle 20 of FILL → immediate clear. A new start afterwards yields the correct full kernel.
